// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: ALU operation codes,
// the opcode/funct values the controller understands, and the FSM state set.
package mips_pkg;

  // ALU operation codes driven on alu_control
  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_ANDI = 5'b00001;
  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_ADDI = 5'b00011;
  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00111;
  localparam logic [4:0] ALU_LW   = 5'b01000;
  localparam logic [4:0] ALU_SW   = 5'b01001;
  localparam logic [4:0] ALU_BEQ  = 5'b01010;
  localparam logic [4:0] ALU_JAL  = 5'b01011;
  localparam logic [4:0] ALU_NOR  = 5'b01100;
  localparam logic [4:0] ALU_JR   = 5'b01111;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // Controller states. ILLEGAL and TIMEOUT are the one-cycle states that
  // carry the illegal_op / mem_timeout pulses back to FETCH.
  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_R     = 4'd8,
    ST_WB_I     = 4'd9,
    ST_WB_MEM   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JAL      = 4'd12,
    ST_JR       = 4'd13,
    ST_ILLEGAL  = 4'd14,
    ST_TIMEOUT  = 4'd15
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// R-type funct to ALU operation decoder. Functs outside the supported set
// raise illegal and leave the code at the AND default.
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [4:0] alu_code,
  output logic       illegal
);

  // Map each supported funct onto its ALU code
  always_comb begin
    alu_code = ALU_AND;
    illegal  = 1'b0;
    case (funct)
      FN_ADD:  alu_code = ALU_ADD;
      FN_AND:  alu_code = ALU_AND;
      FN_NOR:  alu_code = ALU_NOR;
      FN_SLT:  alu_code = ALU_SLT;
      FN_SLL:  alu_code = ALU_SLL;
      FN_JR:   alu_code = ALU_JR;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Sequences fetch/decode/execute/memory/writeback,
// drives the datapath selects and strobes, and bounds every memory wait with a
// counter that aborts back to FETCH after WAIT_LIMIT unanswered request cycles.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_signal,
  input  logic       mem_ready,
  output logic [4:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [5:0]       op_q;
  logic [5:0]       funct_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_st;
  logic             wait_expired;
  logic [5:0]       funct_sel;
  logic [4:0]       dec_code;
  logic             dec_illegal;

  // DECODE dispatches on the live funct; later states use the captured copy
  assign funct_sel = (state == ST_DECODE) ? funct : funct_q;

  mips_alu_decode u_alu_decode (
    .funct    (funct_sel),
    .alu_code (dec_code),
    .illegal  (dec_illegal)
  );

  assign wait_st      = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
  // Last permitted wait cycle with no answer; a ready on this cycle still wins
  assign wait_expired = wait_st && !mem_ready && (wait_cnt == CNT_LAST);
  assign state_o      = state;

  // State register, forced to RST asynchronously so a reset kills any strobe at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RST;
    else        state <= state_nxt;
  end

  // Wait counter restarts whenever a wait state is entered and counts while it holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               wait_cnt <= '0;
    else if (!wait_st || state_nxt != state)  wait_cnt <= '0;
    else                                      wait_cnt <= wait_cnt + 1'b1;
  end

  // Capture the instruction fields while DECODE dispatches on them
  always_ff @(posedge clk) begin
    if (state == ST_DECODE) begin
      op_q    <= opcode;
      funct_q <= funct;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)         state_nxt = ST_DECODE;
        else if (wait_expired) state_nxt = ST_TIMEOUT;
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_JR)   state_nxt = ST_JR;
            else if (dec_illegal) state_nxt = ST_ILLEGAL;
            else                  state_nxt = ST_EXEC_R;
          end
          OP_ADDI, OP_ANDI: state_nxt = ST_EXEC_I;
          OP_LW, OP_SW:     state_nxt = ST_MEM_ADDR;
          OP_BEQ:           state_nxt = ST_BRANCH;
          OP_JAL:           state_nxt = ST_JAL;
          default:          state_nxt = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R:   state_nxt = ST_WB_R;
      ST_EXEC_I:   state_nxt = ST_WB_I;
      ST_MEM_ADDR: state_nxt = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready)         state_nxt = ST_WB_MEM;
        else if (wait_expired) state_nxt = ST_TIMEOUT;
      end
      ST_MEM_WR: begin
        if (mem_ready)         state_nxt = ST_FETCH;
        else if (wait_expired) state_nxt = ST_TIMEOUT;
      end
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JAL, ST_JR,
      ST_ILLEGAL, ST_TIMEOUT: state_nxt = ST_FETCH;
      default: state_nxt = ST_RST;
    endcase
  end

  // Datapath controls per state; every strobe idles low and the ALU idles on AND
  always_comb begin
    alu_control = ALU_AND;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_source   = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 2'b00;
    mem_to_reg  = 2'b00;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      ST_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_control = dec_code;
      end
      ST_EXEC_I: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = (op_q == OP_ADDI) ? ALU_ADDI : ALU_ANDI;
      end
      ST_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = (op_q == OP_SW) ? ALU_SW : ALU_LW;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      ST_WB_I: begin
        reg_write = 1'b1;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      ST_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_BEQ;
        pc_source   = 2'b01;
        pc_write    = zero_signal;
      end
      ST_JAL: begin
        reg_write   = 1'b1;
        reg_dst     = 2'b10;
        mem_to_reg  = 2'b10;
        pc_write    = 1'b1;
        pc_source   = 2'b10;
        alu_control = ALU_JAL;
      end
      ST_JR: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_JR;
        pc_write    = 1'b1;
        pc_source   = 2'b11;
      end
      ST_ILLEGAL: illegal_op  = 1'b1;
      ST_TIMEOUT: mem_timeout = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed cases followed by random instructions
// with random memory latencies, each judged against per-instruction expectations
// (cycle count, strobe counts, selects at writeback) derived from the instruction class.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  localparam int LIMIT = 4;

  localparam int C_R = 0, C_JR = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BEQ = 5, C_JAL = 6, C_ILL = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_signal;
  logic       mem_ready;
  logic [4:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       mem_req;
  logic       mem_we;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state_o;

  int vectors     = 0;
  int miscompares = 0;

  mips_multicycle_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero_signal (zero_signal),
    .mem_ready   (mem_ready),
    .alu_control (alu_control),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .i_or_d      (i_or_d),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_source   (pc_source),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Instruction class from the opcode/funct table
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) return C_JR;
        if (fn == 6'b100000 || fn == 6'b100100 || fn == 6'b100111 ||
            fn == 6'b101010 || fn == 6'b000000) return C_R;
        return C_ILL;
      end
      6'b001000, 6'b001100: return C_I;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000011: return C_JAL;
      default:   return C_ILL;
    endcase
  endfunction

  // ALU code expected in the cycle right after DECODE
  function automatic int exec_alu(input int cls, input logic [5:0] op, input logic [5:0] fn);
    case (cls)
      C_R: begin
        case (fn)
          6'b100000: return 5'b00010;
          6'b100100: return 5'b00000;
          6'b100111: return 5'b01100;
          6'b101010: return 5'b00111;
          default:   return 5'b00100;
        endcase
      end
      C_JR:  return 5'b01111;
      C_I:   return (op == 6'b001000) ? 5'b00011 : 5'b00001;
      C_LW:  return 5'b01000;
      C_SW:  return 5'b01001;
      C_BEQ: return 5'b01010;
      C_JAL: return 5'b01011;
      default: return 5'b00000;
    endcase
  endfunction

  // Run one instruction starting in FETCH at a falling edge: wf unanswered fetch
  // cycles, wm unanswered data cycles (an abort once wm reaches LIMIT).
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm);
    int  cls, fetch_len, mem_start, mem_len, total;
    bit  is_mem, mem_abort, exp_pcw_ex;
    int  n_fetch, n_ir, n_pcw, n_rw, n_we, n_req, n_ill, n_to;
    int  rw_sel, ex_alu, ex_pcw, ex_pcsrc, ex_srca;
    int  exp_rw, exp_sel, exp_pcsrc;
    cls       = classify(op, fn);
    is_mem    = (cls == C_LW) || (cls == C_SW);
    mem_abort = is_mem && (wm >= LIMIT);
    fetch_len = wf + 1;
    mem_start = fetch_len + 2;
    mem_len   = is_mem ? (mem_abort ? LIMIT : wm + 1) : 0;
    case (cls)
      C_R, C_I: total = fetch_len + 3;
      C_LW:     total = mem_start + mem_len + 1;
      C_SW:     total = mem_start + mem_len + (mem_abort ? 1 : 0);
      default:  total = fetch_len + 2;
    endcase
    n_fetch = 0; n_ir = 0; n_pcw = 0; n_rw = 0; n_we = 0; n_req = 0; n_ill = 0; n_to = 0;
    rw_sel = -1; ex_alu = -1; ex_pcw = -1; ex_pcsrc = -1; ex_srca = -1;
    opcode = op;
    funct  = fn;
    for (int c = 0; c < total; c++) begin
      if (c < fetch_len) mem_ready = (c == wf);
      else if (is_mem && c >= mem_start && c < mem_start + mem_len)
        mem_ready = !mem_abort && (c == mem_start + mem_len - 1);
      else mem_ready = 1'($urandom_range(0, 1));
      zero_signal = (c == fetch_len + 1) ? z : 1'($urandom_range(0, 1));
      #1;
      if (state_o === ST_FETCH) n_fetch++;
      n_ir  += int'(ir_write);
      n_pcw += int'(pc_write);
      n_req += int'(mem_req);
      n_we  += int'(mem_we && mem_req);
      n_ill += int'(illegal_op);
      n_to  += int'(mem_timeout);
      if (reg_write) begin
        n_rw++;
        rw_sel = int'({reg_dst, mem_to_reg});
      end
      if (c == fetch_len + 1) begin
        ex_alu   = int'(alu_control);
        ex_pcw   = int'(pc_write);
        ex_pcsrc = int'(pc_source);
        ex_srca  = int'(alu_src_a);
      end
      @(negedge clk);
    end
    #1;
    check({tag, " back_in_fetch"}, int'(state_o), int'(ST_FETCH));
    check({tag, " fetch_cycles"}, n_fetch, fetch_len);
    check({tag, " ir_write_count"}, n_ir, 1);
    exp_pcw_ex = (cls == C_BEQ) ? z : ((cls == C_JAL) || (cls == C_JR));
    check({tag, " pc_write_count"}, n_pcw, 1 + int'(exp_pcw_ex));
    check({tag, " exec_pc_write"}, ex_pcw, int'(exp_pcw_ex));
    if (exp_pcw_ex) begin
      exp_pcsrc = (cls == C_BEQ) ? 1 : (cls == C_JAL) ? 2 : 3;
      check({tag, " pc_source"}, ex_pcsrc, exp_pcsrc);
    end
    exp_rw  = (cls == C_R || cls == C_I || cls == C_JAL || (cls == C_LW && !mem_abort)) ? 1 : 0;
    check({tag, " reg_write_count"}, n_rw, exp_rw);
    if (exp_rw == 1) begin
      exp_sel = (cls == C_R) ? 4'b0100 : (cls == C_LW) ? 4'b0001 : (cls == C_JAL) ? 4'b1010 : 4'b0000;
      check({tag, " wb_dst_m2r"}, rw_sel, exp_sel);
    end
    check({tag, " mem_we_cycles"}, n_we, (cls == C_SW) ? mem_len : 0);
    check({tag, " mem_req_cycles"}, n_req, fetch_len + mem_len);
    check({tag, " illegal_pulses"}, n_ill, (cls == C_ILL) ? 1 : 0);
    check({tag, " timeout_pulses"}, n_to, mem_abort ? 1 : 0);
    check({tag, " exec_alu"}, ex_alu, exec_alu(cls, op, fn));
    check({tag, " exec_src_a"}, ex_srca, (cls == C_JAL || cls == C_ILL) ? 0 : 1);
  endtask

  logic [5:0] rop [14];
  logic [5:0] rfn [14];
  logic [5:0] bad_ops [3];

  initial begin
    int idx;
    logic [5:0] op;
    rop = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000,
            6'b001100, 6'b100011, 6'b101011, 6'b000100, 6'b000011, 6'b111111, 6'b000000};
    rfn = '{6'b100000, 6'b100100, 6'b100111, 6'b101010, 6'b000000, 6'b001000, 6'b000000,
            6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b100010};
    bad_ops = '{6'b111111, 6'b000010, 6'b001101};

    rst_n       = 1'b0;
    opcode      = 6'b000000;
    funct       = 6'b100000;
    zero_signal = 1'b0;
    mem_ready   = 1'b1;

    // Reset held for three cycles, released at a falling edge
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset state", int'(state_o), int'(ST_RST));
    check("reset outputs", int'({alu_control, alu_src_a, alu_src_b, mem_req, mem_we, i_or_d,
                                 ir_write, pc_write, pc_source, reg_write, reg_dst, mem_to_reg,
                                 illegal_op, mem_timeout}), 0);
    @(negedge clk);
    #1;
    check("first fetch state", int'(state_o), int'(ST_FETCH));
    check("first fetch strobes", int'({mem_req, i_or_d, ir_write, pc_write, alu_src_a, alu_src_b, alu_control}),
          int'({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 5'b00010}));

    // Directed instructions
    run_instr("add",      6'b000000, 6'b100000, 1'b0, 0, 0);
    run_instr("lw_w2",    6'b100011, 6'b000000, 1'b0, 0, 2);
    run_instr("beq_z1",   6'b000100, 6'b000000, 1'b1, 0, 0);
    run_instr("beq_z0",   6'b000100, 6'b000000, 1'b0, 0, 0);
    run_instr("ill_op",   6'b111111, 6'b000000, 1'b0, 0, 0);
    run_instr("ill_fn",   6'b000000, 6'b100010, 1'b0, 0, 0);
    run_instr("jal",      6'b000011, 6'b000000, 1'b0, 0, 0);
    run_instr("jr",       6'b000000, 6'b001000, 1'b0, 0, 0);
    run_instr("sw",       6'b101011, 6'b000000, 1'b0, 0, 0);
    run_instr("addi",     6'b001000, 6'b000000, 1'b0, 1, 0);
    run_instr("andi",     6'b001100, 6'b000000, 1'b0, 0, 0);
    run_instr("and",      6'b000000, 6'b100100, 1'b0, 0, 0);
    run_instr("nor",      6'b000000, 6'b100111, 1'b0, 0, 0);
    run_instr("slt",      6'b000000, 6'b101010, 1'b0, 0, 0);
    run_instr("sll",      6'b000000, 6'b000000, 1'b0, 0, 0);
    run_instr("ready_on_limit", 6'b000000, 6'b100000, 1'b0, LIMIT - 1, 0);
    run_instr("sw_ready_on_limit", 6'b101011, 6'b000000, 1'b0, 0, LIMIT - 1);
    run_instr("lw_timeout", 6'b100011, 6'b000000, 1'b0, 0, LIMIT);
    run_instr("sw_timeout", 6'b101011, 6'b000000, 1'b0, 0, LIMIT + 1);

    // Fetch never answered: LIMIT request cycles, one timeout pulse, FETCH again
    opcode = 6'b000000;
    funct  = 6'b100000;
    for (int c = 0; c <= LIMIT; c++) begin
      mem_ready = 1'b0;
      #1;
      if (c < LIMIT) check("fetch wait hold", int'({state_o, mem_timeout}), int'({ST_FETCH, 1'b0}));
      else check("fetch timeout pulse", int'({mem_timeout, mem_req, ir_write, pc_write, reg_write, mem_we}),
                 int'(6'b100000));
      @(negedge clk);
    end
    run_instr("after_fetch_timeout", 6'b000000, 6'b100100, 1'b0, 0, 0);

    // Random instructions and latencies
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 13);
      op  = (idx == 12) ? bad_ops[$urandom_range(0, 2)] : rop[idx];
      run_instr($sformatf("rnd%0d", n), op, rfn[idx], 1'($urandom_range(0, 1)),
                $urandom_range(0, LIMIT - 1), $urandom_range(0, LIMIT + 1));
    end

    // Reset asserted while a store is in MEM_WR
    opcode = 6'b101011;
    funct  = 6'b000000;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mem_wr before reset", int'({mem_req, mem_we, i_or_d}), int'(3'b111));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid reset write drop", int'({mem_req, mem_we, reg_write, pc_write}), 0);
    check("mid reset state", int'(state_o), int'(ST_RST));
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("post reset state", int'(state_o), int'(ST_RST));
    @(negedge clk);
    run_instr("after_mid_reset", 6'b000000, 6'b100000, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
